run_length_monitor: RTL and testbench

Downstream consumer of the consecutive-ones detector's registered flag `z`. It measures the length, in clock cycles, of every interval during which `z` stays high. Each qualifying length is reported through a one-entry valid/ready output buffer. The block also keeps a saturating count of runs and a sticky overflow flag for results it had to drop.

---
 rtl/run_length_monitor.sv | 129 ++++++++++++
 tb/tb_run_length_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/run_length_monitor.sv
// rtl/run_length_monitor.sv - measures high intervals of z, buffers each qualifying length
// Optional max-length tracking is enabled by defining RUN_MON_MAX_EN.
module run_length_monitor #(
  parameter int LEN_W   = 8,
  parameter int CNT_W   = 16,
  parameter int MIN_LEN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             z,
  input  logic             clr,
  input  logic             len_ready,
  output logic             len_valid,
  output logic [LEN_W-1:0] len,
  output logic             len_sat,
  output logic             busy,
  output logic [CNT_W-1:0] run_count,
  output logic             ovf,
  output logic [LEN_W-1:0] max_len
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] MIN_V   = LEN_W'(MIN_LEN);

  state_t           state;
  logic [LEN_W-1:0] run_len;
  logic             sat;

  logic run_end;
  logic qual;
  logic load;
  logic drop;

  // A run ends on the first z=0 sample in RUN; short runs are ignored entirely.
  assign run_end = (state == RUN) && !z;
  assign qual    = run_end && (run_len >= MIN_V);
  // The buffer can take a new result when empty or when it is being drained this cycle.
  assign load    = qual && (!len_valid || len_ready);
  assign drop    = qual && !load;

  // Run FSM: counts z=1 samples, saturating, and remembers whether clipping happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      run_len <= '0;
      sat     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (z) begin
            state   <= RUN;
            run_len <= LEN_W'(1);
            sat     <= 1'b0;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (z) begin
            if (run_len == LEN_MAX) begin
              sat <= 1'b1;
            end else begin
              run_len <= run_len + LEN_W'(1);
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry output buffer; len/len_sat keep their last value after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_valid <= 1'b0;
      len       <= '0;
      len_sat   <= 1'b0;
    end else if (load) begin
      len_valid <= 1'b1;
      len       <= run_len;
      len_sat   <= sat;
    end else if (len_valid && len_ready) begin
      len_valid <= 1'b0;
    end
  end

  // Saturating run counter and sticky drop flag; clr overrides same-cycle updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_count <= '0;
      ovf       <= 1'b0;
    end else if (clr) begin
      run_count <= '0;
      ovf       <= 1'b0;
    end else begin
      if (qual && (run_count != CNT_MAX)) begin
        run_count <= run_count + CNT_W'(1);
      end
      if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef RUN_MON_MAX_EN
  // Longest qualifying run, including results that were dropped at the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_len <= '0;
    end else if (clr) begin
      max_len <= '0;
    end else if (qual && (run_len > max_len)) begin
      max_len <= run_len;
    end
  end
`else
  assign max_len = '0;
`endif

endmodule

// File: tb/tb_run_length_monitor.sv
// tb/tb_run_length_monitor.sv - randomized bench with an integer-counting reference model
module tb_run_length_monitor;

  localparam int LEN_W   = 8;
  localparam int CNT_W   = 4;
  localparam int MIN_LEN = 2;
  localparam int LEN_MAX = (1 << LEN_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             z = 1'b0;
  logic             clr = 1'b0;
  logic             len_ready = 1'b0;
  logic             len_valid;
  logic [LEN_W-1:0] len;
  logic             len_sat;
  logic             busy;
  logic [CNT_W-1:0] run_count;
  logic             ovf;
  logic [LEN_W-1:0] max_len;

  run_length_monitor #(.LEN_W(LEN_W), .CNT_W(CNT_W), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst), .z(z), .clr(clr), .len_ready(len_ready),
    .len_valid(len_valid), .len(len), .len_sat(len_sat), .busy(busy),
    .run_count(run_count), .ovf(ovf), .max_len(max_len)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: the run is just a count of consecutive z=1 samples.
  int run_n;
  int m_valid;
  int m_len;
  int m_sat;
  int m_cnt;
  int m_ovf;
  int m_max;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    run_n = 0; m_valid = 0; m_len = 0; m_sat = 0;
    m_cnt = 0; m_ovf = 0; m_max = 0;
  endtask

  task automatic model_step();
    int n;
    int eff;
    bit ended;
    bit qual;
    bit take;
    bit drain;
    drain = (m_valid != 0) && len_ready;
    ended = !z && (run_n > 0);
    n = run_n;
    run_n = z ? run_n + 1 : 0;
    eff = (n > LEN_MAX) ? LEN_MAX : n;
    qual = ended && (eff >= MIN_LEN);
    take = qual && (m_valid == 0 || len_ready);
    if (take) begin
      m_valid = 1; m_len = eff; m_sat = (n > LEN_MAX) ? 1 : 0;
    end else if (drain) begin
      m_valid = 0;
    end
    if (clr) begin
      m_cnt = 0; m_ovf = 0; m_max = 0;
    end else begin
      if (qual && m_cnt < CNT_MAX) m_cnt++;
      if (qual && !take) m_ovf = 1;
      if (qual && eff > m_max) m_max = eff;
    end
  endtask

  task automatic compare_all();
    int exp_max;
`ifdef RUN_MON_MAX_EN
    exp_max = m_max;
`else
    exp_max = 0;
`endif
    check_eq("len_valid", 32'(len_valid), 32'(m_valid));
    check_eq("len", 32'(len), 32'(m_len));
    check_eq("len_sat", 32'(len_sat), 32'(m_sat));
    check_eq("busy", 32'(busy), (run_n > 0) ? 32'd1 : 32'd0);
    check_eq("run_count", 32'(run_count), 32'(m_cnt));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("max_len", 32'(max_len), 32'(exp_max));
  endtask

  task automatic cyc(input logic zv, input logic rv, input logic cv);
    z = zv; len_ready = rv; clr = cv;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic zr;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // 5-cycle run, consumer ready
    repeat (5) cyc(1'b1, 1'b1, 1'b0);
    check_eq("tp1_busy", 32'(busy), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("tp1_valid", 32'(len_valid), 32'd1);
    check_eq("tp1_len", 32'(len), 32'd5);
    check_eq("tp1_cnt", 32'(run_count), 32'd1);
    check_eq("tp1_busy_low", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("tp1_drain", 32'(len_valid), 32'd0);

    // single-cycle run is below MIN_LEN
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("tp2_valid", 32'(len_valid), 32'd0);
    check_eq("tp2_cnt", 32'(run_count), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);

    // stalled consumer: second result dropped
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check_eq("tp3_len", 32'(len), 32'd3);
    check_eq("tp3_cnt", 32'(run_count), 32'd2);
    check_eq("tp3_ovf", 32'(ovf), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("tp3_drain", 32'(len_valid), 32'd0);

    // saturation
    cyc(1'b0, 1'b1, 1'b1);
    repeat (300) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("tp4_len", 32'(len), 32'd255);
    check_eq("tp4_sat", 32'(len_sat), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);

    // accept and load in the same cycle
    cyc(1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    check_eq("tp5_valid", 32'(len_valid), 32'd1);
    check_eq("tp5_len", 32'(len), 32'd6);
    check_eq("tp5_ovf", 32'(ovf), 32'd0);
    cyc(1'b0, 1'b1, 1'b0);

    // asynchronous reset mid-run
    repeat (10) cyc(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    z = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;

    // clr coincident with a qualifying run end
    repeat (3) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    check_eq("tp6_cnt", 32'(run_count), 32'd0);
    check_eq("tp6_ovf", 32'(ovf), 32'd0);
    check_eq("tp6_valid", 32'(len_valid), 32'd1);

    // randomized traffic
    zr = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (zr) zr = ($urandom_range(0, 99) < 75);
      else    zr = ($urandom_range(0, 99) < 45);
      cyc(zr, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
